tdemux_1_4: RTL and testbench
=============================

# tdemux_1_4

Time-division 1:4 demultiplexer: the receive-side counterpart of the 4:1 lane mux. It accepts one WIDTH-bit beat per valid cycle on a single input, steers successive beats into lanes 0..3 using an internal 2-bit slot counter, and presents the completed 4-lane frame atomically on `y` with a one-cycle `frame_valid` pulse. Frame alignment comes from a `sync` marker on the slot-0 beat. The block sits downstream of the lane mux / serial link and feeds parallel consumers.

## Interface
- `WIDTH`, default 1: bits per lane/beat.
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `d` input WIDTH: beat data.
- `valid` input 1: `d`/`sync` are sampled this cycle.
- `sync` input 1: marks the current beat as slot 0; ignored unless `valid`.
- `y` output 4*WIDTH: last completed frame; lane i = `y[i*WIDTH +: WIDTH]`.
- `frame_valid` output 1: one-cycle pulse, `y` just updated.
- `s` output 2: slot the next accepted beat will fill.
- `locked` output 1: high in LOCKED state.
- `sync_err` output 1: one-cycle pulse on alignment violation.

## Operation
- States: HUNT (reset state) and LOCKED.
- Internal shadow register holds lanes 0..2 of the frame in progress; `y` changes only on frame completion.
- HUNT: beats with `valid & !sync` are discarded, no pulses. `valid & sync` stores `d` in shadow lane 0, sets `s`=1, enters LOCKED.
- LOCKED, `valid & !sync`, `s`!=0: store `d` in shadow lane `s`, `s`<=`s`+1 (mod 4).
- LOCKED, `valid`, `s`==3: `y` <= {d, shadow lanes 2,1,0}, `frame_valid` pulses, `s` wraps to 0.
- LOCKED, `valid & sync`, `s`==0: normal slot-0 beat, lane 0 stored, `s`=1.
- LOCKED, `valid & sync`, `s`!=0: early sync. `sync_err` pulses, partial frame discarded, beat taken as new slot 0, `s`=1, stay LOCKED. `y` is unchanged.
- LOCKED, `valid & !sync`, `s`==0: behaviour depends on the configuration macro (see Configuration).
- `valid`=0: no state change and no pulses. Gaps of any length between beats are legal.
- `frame_valid` and `sync_err` are never high in the same cycle.

## Timing
- Reset values after a `rst`-high edge: `y`=0, `frame_valid`=0, `sync_err`=0, `s`=0, `locked`=0, shadow=0, state HUNT.
- `rst` mid-frame discards the partial frame. `rst` has priority over `valid`.
- All outputs are registered. Latency is one cycle: the slot-3 beat is sampled at edge k, and `y`, `frame_valid` and `s`=0 are visible after edge k.
- `locked` rises after the edge that samples the first `valid & sync` beat.
- `sync_err` is high for exactly the cycle following the offending beat's sampling edge.
- Minimum frame is 4 consecutive valid cycles, so `frame_valid` can pulse at most every 4th cycle.

## Configuration
- Macro: `TDEMUX_SYNC_CHECK_EN`.
- When defined, in LOCKED a `valid & !sync` beat at `s`==0 is an alignment loss:
  - `sync_err` pulses and the beat is discarded.
  - state returns to HUNT, `locked`=0, `s`=0.
- When not defined, sync is needed only to acquire lock. A `valid & !sync` beat at `s`==0 in LOCKED is accepted as lane 0 (free-running framing) and no `sync_err` is raised.
- Early-sync handling is identical in both builds.

## Test plan
- Reset then basic frame, WIDTH=1: beats d=1(sync),0,1,1 on 4 consecutive cycles -> one cycle after the 4th beat `y`=4'b1101 and `frame_valid`=1 for one cycle; `locked`=1 from after beat 1.
- HUNT discard: beats d=1,1 with `sync`=0, then frame 0(sync),1,0,0 -> `y`=4'b0010 and exactly one `frame_valid`.
- Gapped beats: frame 1(sync),1,0,1 with 3 idle cycles between each beat -> `y`=4'b1011 after the last beat, `s` steps 1,2,3,0 and holds during the gaps, no extra pulses.
- Early sync: beats 1(sync),1, then 0(sync),0,1,1 -> `sync_err` pulse after the third beat, `y`=4'b1100 after the sixth beat, and the previous `y` is held until then.
- Missing sync at slot 0 after a good frame, then beats 1,1,1,1 without sync:
  - with `TDEMUX_SYNC_CHECK_EN`: `sync_err` pulse, `locked`=0, no new `frame_valid`.
  - without the macro: `y`=4'b1111 and `frame_valid` pulses.
- Reset mid-frame: 2 beats of a frame, then `rst` for one cycle -> all outputs 0 and HUNT; the next full synced frame 0,1,1,0 gives `y`=4'b0110.

Source files
------------

// File: rtl/tdemux_1_4.sv
// tdemux_1_4: time-division 1:4 demux; sync-marked beats fill 4 lanes, frame on y.
// Build macro TDEMUX_SYNC_CHECK_EN: a missing sync at slot 0 drops lock instead of free-running.
module tdemux_1_4 #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   d,
    input  logic               valid,
    input  logic               sync,
    output logic [4*WIDTH-1:0] y,
    output logic               frame_valid,
    output logic [1:0]         s,
    output logic               locked,
    output logic               sync_err
);
`ifdef TDEMUX_SYNC_CHECK_EN
    localparam bit SYNC_CHECK = 1'b1;
`else
    localparam bit SYNC_CHECK = 1'b0;
`endif

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t             state;
    logic [3*WIDTH-1:0] shadow;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            shadow      <= '0;
            y           <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            s           <= 2'd0;
            locked      <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            if (valid) begin
                if (state == HUNT) begin
                    if (sync) begin
                        shadow[WIDTH-1:0] <= d;
                        s                 <= 2'd1;
                        state             <= LOCKED;
                        locked            <= 1'b1;
                    end
                end else if (sync && s != 2'd0) begin
                    // early sync restarts the frame with this beat as lane 0
                    shadow[WIDTH-1:0] <= d;
                    s                 <= 2'd1;
                    sync_err          <= 1'b1;
                end else if (s == 2'd3) begin
                    y           <= {d, shadow};
                    frame_valid <= 1'b1;
                    s           <= 2'd0;
                end else if (SYNC_CHECK && !sync && s == 2'd0) begin
                    sync_err <= 1'b1;
                    state    <= HUNT;
                    locked   <= 1'b0;
                end else begin
                    shadow[s*WIDTH +: WIDTH] <= d;
                    s                        <= s + 2'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_tdemux_1_4.sv
// tb_tdemux_1_4: table-driven directed checks of tdemux_1_4 at WIDTH=1.
module tb_tdemux_1_4;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [0:0] d = '0;
    logic       valid = 1'b0;
    logic       sync = 1'b0;
    logic [3:0] y;
    logic       frame_valid;
    logic [1:0] s;
    logic       locked;
    logic       sync_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst, valid, sync, d;
        logic [3:0] y;
        logic       fv;
        logic [1:0] s;
        logic       lk, er;
    } vec_t;

    vec_t vq[$];

    tdemux_1_4 #(.WIDTH(1)) dut (
        .clk(clk), .rst(rst), .d(d), .valid(valid), .sync(sync),
        .y(y), .frame_valid(frame_valid), .s(s), .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    function automatic void v(input logic r, va, sy, dd, input logic [3:0] ey,
                              input logic efv, input logic [1:0] es, input logic elk, eer);
        vec_t t;
        t.rst = r; t.valid = va; t.sync = sy; t.d = dd;
        t.y = ey; t.fv = efv; t.s = es; t.lk = elk; t.er = eer;
        vq.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, va, sy, dd);
        rst = r; valid = va; sync = sy; d = dd;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] ey, input logic efv,
                           input logic [1:0] es, input logic elk, eer);
        chk({tag, ".y"}, y, ey);
        chk({tag, ".frame_valid"}, {3'b0, frame_valid}, {3'b0, efv});
        chk({tag, ".s"}, {2'b0, s}, {2'b0, es});
        chk({tag, ".locked"}, {3'b0, locked}, {3'b0, elk});
        chk({tag, ".sync_err"}, {3'b0, sync_err}, {3'b0, eer});
    endtask

    initial begin
        // reset, then basic frame 1(sync),0,1,1
        v(1,0,0,0, 4'b0000,0,0,0,0);
        v(1,0,0,0, 4'b0000,0,0,0,0);
        v(0,1,1,1, 4'b0000,0,1,1,0);
        v(0,1,0,0, 4'b0000,0,2,1,0);
        v(0,1,0,1, 4'b0000,0,3,1,0);
        v(0,1,0,1, 4'b1101,1,0,1,0);
        v(0,0,0,0, 4'b1101,0,0,1,0);
        // HUNT discards unsynced beats
        v(1,0,0,0, 4'b0000,0,0,0,0);
        v(0,1,0,1, 4'b0000,0,0,0,0);
        v(0,1,0,1, 4'b0000,0,0,0,0);
        v(0,1,1,0, 4'b0000,0,1,1,0);
        v(0,1,0,1, 4'b0000,0,2,1,0);
        v(0,1,0,0, 4'b0000,0,3,1,0);
        v(0,1,0,0, 4'b0010,1,0,1,0);
        v(0,0,0,0, 4'b0010,0,0,1,0);
        // early sync at slot 2
        v(0,1,1,1, 4'b0010,0,1,1,0);
        v(0,1,0,1, 4'b0010,0,2,1,0);
        v(0,1,1,0, 4'b0010,0,1,1,1);
        v(0,1,0,0, 4'b0010,0,2,1,0);
        v(0,1,0,1, 4'b0010,0,3,1,0);
        v(0,1,0,1, 4'b1100,1,0,1,0);
        v(0,0,0,0, 4'b1100,0,0,1,0);
        // missing sync at slot 0 after a good frame
`ifdef TDEMUX_SYNC_CHECK_EN
        v(0,1,0,1, 4'b1100,0,0,0,1);
        v(0,1,0,1, 4'b1100,0,0,0,0);
        v(0,1,0,1, 4'b1100,0,0,0,0);
        v(0,1,0,1, 4'b1100,0,0,0,0);
`else
        v(0,1,0,1, 4'b1100,0,1,1,0);
        v(0,1,0,1, 4'b1100,0,2,1,0);
        v(0,1,0,1, 4'b1100,0,3,1,0);
        v(0,1,0,1, 4'b1111,1,0,1,0);
`endif
        // reset mid-frame, reset beats a valid sync beat
        v(1,0,0,0, 4'b0000,0,0,0,0);
        v(0,1,1,1, 4'b0000,0,1,1,0);
        v(0,1,0,1, 4'b0000,0,2,1,0);
        v(1,1,1,1, 4'b0000,0,0,0,0);
        v(0,1,1,0, 4'b0000,0,1,1,0);
        v(0,1,0,1, 4'b0000,0,2,1,0);
        v(0,1,0,1, 4'b0000,0,3,1,0);
        v(0,1,0,0, 4'b0110,1,0,1,0);
        // early sync on the slot-3 beat takes priority over completion
        v(0,1,1,1, 4'b0110,0,1,1,0);
        v(0,1,0,0, 4'b0110,0,2,1,0);
        v(0,1,0,0, 4'b0110,0,3,1,0);
        v(0,1,1,1, 4'b0110,0,1,1,1);
        v(0,1,0,0, 4'b0110,0,2,1,0);
        v(0,1,0,0, 4'b0110,0,3,1,0);
        v(0,1,0,0, 4'b0001,1,0,1,0);

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].valid, vq[i].sync, vq[i].d);
            chk_all($sformatf("vec%0d", i), vq[i].y, vq[i].fv, vq[i].s, vq[i].lk, vq[i].er);
        end

        // gapped frame 1(sync),1,0,1 with 3 idle cycles after each beat
        begin
            logic [3:0] bits = 4'b1011;
            for (int b = 0; b < 4; b++) begin
                step(0, 1, b == 0, bits[b]);
                chk_all($sformatf("gap_beat%0d", b), b == 3 ? 4'b1011 : 4'b0001,
                        b == 3, 2'(b + 1), 1'b1, 1'b0);
                for (int g = 0; g < 3; g++) begin
                    step(0, 0, 1, ~bits[b]);
                    chk_all($sformatf("gap_idle%0d_%0d", b, g), b == 3 ? 4'b1011 : 4'b0001,
                            1'b0, 2'(b + 1), 1'b1, 1'b0);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
